// File: rtl/write_back_queue.sv
// write_back_queue
//   Small FIFO between the execute-side result writes and the write-back
//   register. It absorbs producer bursts while the write-back port stalls.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear of all queued entries
//   in_valid/in_ready    producer handshake
//   in_addr/in_data      incoming write (destination address + data)
//   wb_en/wb_ready       write presented to / consumed by write-back register
//   wb_addr/wb_data      presented write
//   count                number of occupied entries
//
// Optional feature macro: WRITE_BACK_QUEUE_BYPASS_EN
//   When defined, a write arriving while the queue is empty and the
//   write-back register is ready is forwarded on wb_* in the same cycle
//   instead of being stored.

module write_back_queue #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 4,
  parameter int DROP_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     wb_en,
  input  logic                     wb_ready,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;

  logic q_en;
  logic drop;
  logic push;
  logic pop;
  logic store;
  logic bypass;

  assign count    = count_q;
  assign q_en     = (count_q != '0);
  // in_ready is purely registered state: no path from wb_ready.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign drop     = (DROP_ZERO != 0) && (in_addr == '0);
  assign push     = in_valid && in_ready;
  assign pop      = q_en && wb_ready;

`ifdef WRITE_BACK_QUEUE_BYPASS_EN
  // Forward straight through only when nothing older is waiting.
  assign bypass  = !q_en && in_valid && !flush && wb_ready && !drop;
  assign wb_en   = q_en || bypass;
  assign wb_addr = bypass ? in_addr : addr_mem[rd_ptr];
  assign wb_data = bypass ? in_data : data_mem[rd_ptr];
`else
  assign bypass  = 1'b0;
  assign wb_en   = q_en;
  assign wb_addr = addr_mem[rd_ptr];
  assign wb_data = data_mem[rd_ptr];
`endif

  // Dropped (address 0) and bypassed writes complete the handshake but
  // never occupy an entry.
  assign store = push && !drop && !bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (store && !flush) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Flush wins over a same-cycle push or pop; storage is left as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_queue.sv
// tb_write_back_queue
//   Scoreboard bench for write_back_queue. The producer side records every
//   accepted write in a reference queue; an independent monitor pops that
//   queue whenever the DUT hands a write to the write-back register.
//   Honours WRITE_BACK_QUEUE_BYPASS_EN when the DUT is built with it.

module tb_write_back_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int DZ     = 1;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [ADDR_W-1:0]      in_addr;
  logic [DATA_W-1:0]      in_data;
  logic                   wb_en;
  logic                   wb_ready;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic [$clog2(DEPTH):0] count;

  write_back_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_ZERO(DZ)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_en(wb_en), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W+DATA_W-1:0] model [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timing inside each 10ns cycle (posedge at P):
  //   P+1 inputs driven; P+6 monitor checks count/flags; P+7 producer
  //   updates the model; P+8 monitor checks write-back pops.
  task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic f, input logic r);
    @(posedge clk);
    #1;
    in_valid = v; in_addr = a; in_data = d; flush = f; wb_ready = r;
  endtask

  task automatic finish_cycle(output logic acc);
    @(negedge clk);
    #2;
    acc = 1'b0;
    if (rst_n && flush) begin
      model.delete();
    end else if (rst_n && in_valid && in_ready) begin
      acc = 1'b1;
      if (!(DZ != 0 && in_addr == '0)) model.push_back({in_addr, in_data});
    end
  endtask

  task automatic cycle(input logic v, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic f, input logic r,
                       output logic acc);
    drive(v, a, d, f, r);
    finish_cycle(acc);
  endtask

  // Monitor: registered flags against model occupancy, then pops.
  initial begin
    logic exp_en;
    logic [ADDR_W+DATA_W-1:0] exp_w;
    forever begin
      @(negedge clk);
      #1;
      exp_en = (model.size() != 0);
`ifdef WRITE_BACK_QUEUE_BYPASS_EN
      if (model.size() == 0 && rst_n && in_valid && !flush && wb_ready &&
          !(DZ != 0 && in_addr == '0)) exp_en = 1'b1;
`endif
      chk("count", 64'(count), 64'(model.size()));
      chk("in_ready", 64'(in_ready), 64'(model.size() != DEPTH));
      chk("wb_en", 64'(wb_en), 64'(exp_en));
      #2;
      if (rst_n && wb_en && wb_ready && !flush) begin
        if (model.size() == 0) begin
          chk("wb_unexpected", 64'({wb_addr, wb_data}), 64'(0));
          if ({wb_addr, wb_data} == '0) begin
            fails++;
            $display("FAIL wb_unexpected: got write with empty model expected none");
          end
        end else begin
          exp_w = model.pop_front();
          chk("wb_pop", 64'({wb_addr, wb_data}), 64'(exp_w));
        end
      end
    end
  end

  initial begin
    logic acc;
    int   n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; wb_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_wb_en", 64'(wb_en), 0);
    chk("rst_wb_addr", 64'(wb_addr), 0);
    chk("rst_wb_data", 64'(wb_data), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;

    // single write, latency
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b1);
`ifdef WRITE_BACK_QUEUE_BYPASS_EN
    chk("byp_wb_en", 64'(wb_en), 1);
    chk("byp_wb_addr", 64'(wb_addr), 3);
    chk("byp_wb_data", 64'(wb_data), 64'hA5A5A5A5);
`endif
    finish_cycle(acc);
    chk("single_acc", 64'(acc), 1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
`ifndef WRITE_BACK_QUEUE_BYPASS_EN
    chk("lat_wb_en", 64'(wb_en), 1);
    chk("lat_wb_addr", 64'(wb_addr), 3);
    chk("lat_wb_data", 64'(wb_data), 64'hA5A5A5A5);
`endif
    finish_cycle(acc);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("single_drained", 64'(count), 0);
    finish_cycle(acc);

    // fill to full under stall, fifth write held, then drain in order
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, ADDR_W'(i), 32'h1000 + DATA_W'(i), 1'b0, 1'b0, acc);
      chk("fill_acc", 64'(acc), 1);
    end
    drive(1'b1, 5'd5, 32'h1005, 1'b0, 1'b0);
    chk("full_count", 64'(count), 4);
    chk("full_in_ready", 64'(in_ready), 0);
    finish_cycle(acc);
    chk("full_held", 64'(acc), 0);
    n = 0;
    do begin
      cycle(1'b1, 5'd5, 32'h1005, 1'b0, 1'b1, acc);
      n++;
    end while (!acc && n < 10);
    chk("fifth_accepted", 64'(acc), 1);
    repeat (6) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // steady push+pop at count 1
    cycle(1'b1, 5'd9, 32'hCAFE0000, 1'b0, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, ADDR_W'($urandom_range(1, 31)), $urandom, 1'b0, 1'b1);
      chk("pp_count", 64'(count), 1);
      finish_cycle(acc);
    end
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // address 0 dropped
    cycle(1'b1, 5'd0, 32'hDEAD0000, 1'b0, 1'b1, acc);
    chk("zero_acc", 64'(acc), 1);
    cycle(1'b1, 5'd7, 32'h77777777, 1'b0, 1'b1, acc);
    chk("seven_acc", 64'(acc), 1);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // flush at count 3 with push and pop pending
    for (int i = 0; i < 3; i++) cycle(1'b1, ADDR_W'(10 + i), $urandom, 1'b0, 1'b0, acc);
    cycle(1'b1, 5'd20, 32'hF1F1F1F1, 1'b1, 1'b1, acc);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 0);
    chk("flush_wb_en", 64'(wb_en), 0);
    finish_cycle(acc);
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // reset mid-burst at count 3
    for (int i = 0; i < 3; i++) cycle(1'b1, ADDR_W'(20 + i), $urandom, 1'b0, 1'b0, acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0; wb_ready = 1'b1; rst_n = 1'b0;
    #1;
    model.delete();
    chk("mrst_count", 64'(count), 0);
    chk("mrst_wb_en", 64'(wb_en), 0);
    chk("mrst_wb_addr", 64'(wb_addr), 0);
    chk("mrst_wb_data", 64'(wb_data), 0);
    chk("mrst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 2) != 0), acc);
    end
    repeat (8) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("final_empty", 64'(model.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
